// File: rtl/note_pkg.sv
// note_pkg: shared constants for the note sequencer slice.
// Holds the fixed state encoding, the song ROM word layout {last, half_period, duration}
// and the rest marker.
package note_pkg;

   localparam logic [3:0] STATE_IDLE  = 4'b0000;
   localparam logic [3:0] STATE_FETCH = 4'b1000;
   localparam logic [3:0] STATE_LOAD  = 4'b0100;
   localparam logic [3:0] STATE_PLAY  = 4'b0010;
   localparam logic [3:0] STATE_DONE  = 4'b0001;

   typedef enum logic [3:0] {
      ST_IDLE  = STATE_IDLE,
      ST_FETCH = STATE_FETCH,
      ST_LOAD  = STATE_LOAD,
      ST_PLAY  = STATE_PLAY,
      ST_DONE  = STATE_DONE
   } state_e;

   // Field offsets for the default widths (PERIOD_W=16, DUR_W=8).
   localparam int DEF_PERIOD_W = 16;
   localparam int DEF_DUR_W    = 8;
   localparam int DUR_LSB      = 0;
   localparam int PERIOD_LSB   = DUR_LSB + DEF_DUR_W;
   localparam int LAST_BIT     = PERIOD_LSB + DEF_PERIOD_W;

   // A half-period of zero marks a rest (silent note).
   localparam int REST = 0;

   // Offsets for arbitrary field widths; same layout as above.
   function automatic int period_lsb(input int dur_w);
      return DUR_LSB + dur_w;
   endfunction

   function automatic int last_bit(input int period_w, input int dur_w);
      return DUR_LSB + dur_w + period_w;
   endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: song ROM bus between the sequencer (master) and the ROM (slave).
// rom_data is valid one clock after rom_addr is presented.
interface note_sequencer_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 25
);
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;

   modport master (output rom_addr, input rom_data);
   modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/DFFRE_RTL.sv
// DFFRE_RTL: W-bit register with synchronous active-low reset and load enable.
module DFFRE_RTL #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   // Load on enable, clear on reset, otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q_o <= {W{1'b0}};
      end else if (en_i) begin
         q_o <= d_i;
      end else begin
         q_o <= q_o;
      end
   end

endmodule

// File: rtl/tick_counter.sv
// tick_counter: modulo-TICK_CYCLES counter with clear and a wrap pulse.
// wrap_o is high in the counting cycle where the count is TICK_CYCLES-1.
module tick_counter #(
   parameter int TICK_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic wrap_o
);

   localparam int              CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             load_s;
   logic             at_last_s;

   assign at_last_s = (cnt_q == CNT_LAST);
   assign wrap_o    = en_i && !clr_i && at_last_s;

   // Next count: clear dominates, otherwise advance and wrap to zero.
   always_comb begin
      cnt_d  = cnt_q;
      load_s = 1'b0;
      if (clr_i) begin
         cnt_d  = {CNT_W{1'b0}};
         load_s = 1'b1;
      end else if (en_i) begin
         load_s = 1'b1;
         cnt_d  = at_last_s ? {CNT_W{1'b0}} : (cnt_q + CNT_ONE);
      end else begin
         load_s = 1'b0;
      end
   end

   DFFRE_RTL #(.W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .en_i (load_s),
      .d_i  (cnt_d),
      .q_o  (cnt_q)
   );

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: walks a song ROM of {last, half_period, duration} entries, presents
// each note's half-period to the note player and times its duration in ticks.
// Optional build macro NOTE_SEQUENCER_LOOP_EN: at the end of the song restart from
// address 0 (pulsing done) instead of returning to IDLE.
module note_sequencer
   import note_pkg::*;
#(
   parameter int ADDR_W      = 5,
   parameter int PERIOD_W    = 16,
   parameter int DUR_W       = 8,
   parameter int TICK_CYCLES = 100000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                play_i,
   input  logic                stop_i,
   note_sequencer_if.master    rom,
   output logic [PERIOD_W-1:0] half_period_o,
   output logic                note_en_o,
   output logic                note_start_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [3:0]          state_o
);

   localparam int                 PER_LSB     = period_lsb(DUR_W);
   localparam int                 LST_BIT     = last_bit(PERIOD_W, DUR_W);
   localparam logic [ADDR_W-1:0]  PTR_MAX     = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0]  PTR_ONE     = ADDR_W'(1);
   localparam logic [DUR_W-1:0]   DUR_ONE     = DUR_W'(1);
   localparam logic [PERIOD_W-1:0] PERIOD_REST = PERIOD_W'(REST);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
   logic                last_q, last_d;
   logic                start_q, start_d;

   logic                rom_last_s;
   logic [PERIOD_W-1:0] rom_period_s;
   logic [DUR_W-1:0]    rom_dur_s;
   logic                ld_end_s;
   logic                pl_end_s;
   logic                end_hit_s;
   logic                done_s;
   logic                tick_en_s;
   logic                tick_clr_s;
   logic                tick_wrap_s;
   logic [ADDR_W-1:0]   rom_addr_s;

   assign rom_last_s   = rom.rom_data[LST_BIT];
   assign rom_period_s = rom.rom_data[PER_LSB +: PERIOD_W];
   assign rom_dur_s    = rom.rom_data[DUR_LSB +: DUR_W];

   // The final ROM address always ends the song, even without its last bit.
   assign ld_end_s = rom_last_s || (ptr_q == PTR_MAX);
   assign pl_end_s = last_q || (ptr_q == PTR_MAX);

   tick_counter #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (tick_clr_s),
      .en_i   (tick_en_s),
      .wrap_o (tick_wrap_s)
   );

   // Next-state, pointer/counter updates and the done pulse; stop overrides last.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      period_d   = period_q;
      dur_cnt_d  = dur_cnt_q;
      last_d     = last_q;
      done_s     = 1'b0;
      end_hit_s  = 1'b0;
      tick_en_s  = 1'b0;
      tick_clr_s = 1'b1;
      rom_addr_s = ptr_q;

      case (state_q)
         ST_IDLE: begin
            rom_addr_s = {ADDR_W{1'b0}};
            if (play_i && !stop_i) begin
               state_d = ST_FETCH;
               ptr_d   = {ADDR_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            period_d  = rom_period_s;
            last_d    = rom_last_s;
            dur_cnt_d = rom_dur_s;
            if (rom_dur_s == {DUR_W{1'b0}}) begin
               // Zero-length entry: skip straight to the next fetch.
               if (ld_end_s) begin
                  end_hit_s = 1'b1;
               end else begin
                  ptr_d   = ptr_q + PTR_ONE;
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            tick_en_s  = 1'b1;
            tick_clr_s = 1'b0;
            if (tick_wrap_s) begin
               dur_cnt_d = dur_cnt_q - DUR_ONE;
               if (dur_cnt_q == DUR_ONE) begin
                  if (pl_end_s) begin
                     end_hit_s = 1'b1;
                  end else begin
                     ptr_d   = ptr_q + PTR_ONE;
                     state_d = ST_FETCH;
                  end
               end else begin
                  state_d = ST_PLAY;
               end
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_DONE: begin
            done_s  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (end_hit_s) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
         state_d = ST_FETCH;
         ptr_d   = {ADDR_W{1'b0}};
         done_s  = 1'b1;
`else
         state_d = ST_DONE;
`endif
      end else begin
         done_s = done_s;
      end

      if (stop_i && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         ptr_d      = {ADDR_W{1'b0}};
         period_d   = {PERIOD_W{1'b0}};
         dur_cnt_d  = {DUR_W{1'b0}};
         last_d     = 1'b0;
         done_s     = 1'b0;
         tick_en_s  = 1'b0;
         tick_clr_s = 1'b1;
      end else begin
         tick_clr_s = tick_clr_s;
      end

      start_d = (state_d == ST_PLAY) && (state_q != ST_PLAY);
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= {ADDR_W{1'b0}};
         period_q  <= {PERIOD_W{1'b0}};
         dur_cnt_q <= {DUR_W{1'b0}};
         last_q    <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         period_q  <= period_d;
         dur_cnt_q <= dur_cnt_d;
         last_q    <= last_d;
         start_q   <= start_d;
      end
   end

   assign rom.rom_addr  = rom_addr_s;
   assign state_o       = state_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign half_period_o = (state_q == ST_PLAY) ? period_q : {PERIOD_W{1'b0}};
   assign note_en_o     = (state_q == ST_PLAY) && (period_q != PERIOD_REST);
   assign note_start_o  = start_q;
   assign done_o        = done_s;

endmodule
